// File: rtl/core_pkg.sv
// Shared definitions for the instruction fetch path: bus widths, default depth, linear address.
// Pure declarations and a combinational helper, so this file adds no latency.
// No flow control lives here; the modules that import it handle backpressure.
package core_pkg;

  localparam int ADDR_W           = 20;
  localparam int DATA_W           = 8;
  localparam int IP_W             = 16;
  localparam int PQ_DEPTH_DEFAULT = 4;

  typedef logic [ADDR_W-1:0] lin_addr_t;
  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [IP_W-1:0]   ip_t;

  // Real-mode linear address: seg*16 + off, truncated to 20 bits (wraps at 1 MiB)
  function automatic lin_addr_t linear_addr(input ip_t seg, input ip_t off);
    lin_addr_t a;
    a = {seg, 4'b0000} + {4'b0000, off};
    return a;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer, DEPTH x 8, with push/pop/clear and an occupancy count.
// A push is visible at the head the cycle after it is written; rdata is read combinationally at head.
// No internal backpressure: the caller only pushes into reserved slots and only pops when count != 0.
module byte_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH = PQ_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o,
  output logic [CNT_W-1:0] count_o
);

  // Storage is deliberately left unreset; only the pointers and count define validity.
  byte_t            mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for pointers and count; clear wins over a simultaneous push or pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop_i) begin
        head_d = head_q + PTR_W'(1);
      end
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Data array write; a push that coincides with clear is discarded
  always_ff @(posedge clock) begin
    if (push_i && !clear_i) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction-byte prefetch queue: issues linear byte reads on idle bus cycles and buffers them for decode.
// Read issued in cycle N is captured at the end of N+1 and presented at the head in N+2.
// Requests stall while bus_busy or while buffered plus in-flight bytes would exceed DEPTH; flush discards all.
module prefetch_queue
  import core_pkg::*;
#(
  parameter int          DEPTH    = PQ_DEPTH_DEFAULT,
  parameter logic [15:0] RESET_IP = 16'h0000,
  localparam int         LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [15:0]      cs,
  input  logic             flush,
  input  logic [15:0]      flush_ip,
  input  logic             q_pop,
  output logic             q_valid,
  output logic [7:0]       q_data,
  output logic [15:0]      q_ip,
  output logic [LVL_W-1:0] q_level,
  input  logic             bus_busy,
  output logic             mem_req,
  output logic [19:0]      mem_address,
  input  logic [7:0]       mem_data
);

  localparam logic [LVL_W-1:0] DEPTH_LIM = LVL_W'(DEPTH);

  ip_t              fip_q, fip_d;
  ip_t              qip_q, qip_d;
  logic             inflight_q, inflight_d;

  logic             fifo_push;
  logic             fifo_pop;
  byte_t            fifo_rdata;
  logic [LVL_W-1:0] fifo_count;
  logic [LVL_W-1:0] reserved;

  // Slots already committed: bytes held plus the one read that may still be returning.
  // The sum never exceeds DEPTH because a request only issues while it is below DEPTH.
  assign reserved = fifo_count + LVL_W'(inflight_q);

  // Fetch request gating; reset_n is included so no request escapes while reset is held
  assign mem_req     = reset_n && !flush && !bus_busy && (reserved < DEPTH_LIM);
  assign mem_address = linear_addr(cs, fip_q);

  // A returning byte lands only if no flush is discarding it this same edge
  assign fifo_push = inflight_q && !flush;
  assign fifo_pop  = q_valid && q_pop && !flush;

  // Next-state for fetch pointer, head IP and the outstanding-read flag; flush has top priority
  always_comb begin
    fip_d      = fip_q;
    qip_d      = qip_q;
    inflight_d = inflight_q;
    if (flush) begin
      fip_d      = flush_ip;
      qip_d      = flush_ip;
      inflight_d = 1'b0;
    end else begin
      if (mem_req) begin
        fip_d      = fip_q + 16'd1;
        inflight_d = 1'b1;
      end else if (inflight_q) begin
        inflight_d = 1'b0;
      end
      if (fifo_pop) begin
        qip_d = qip_q + 16'd1;
      end
    end
  end

  // Fetch-side state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fip_q      <= RESET_IP;
      qip_q      <= RESET_IP;
      inflight_q <= 1'b0;
    end else begin
      fip_q      <= fip_d;
      qip_q      <= qip_d;
      inflight_q <= inflight_d;
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .clear_i (flush),
    .wdata_i (mem_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  // Head data is masked to zero when empty so unwritten storage never reaches the core
  assign q_valid = (fifo_count != '0);
  assign q_data  = q_valid ? fifo_rdata : 8'h00;
  assign q_ip    = qip_q;
  assign q_level = fifo_count;

endmodule
